// File: rtl/sede_param.sv
// -----------------------------------------------------------------------------
// sede_param -- streaming 3x3 Sobel edge-detection engine.
//
// Accepts one raster-order pixel per accepted cycle and emits one edge value
// per pixel, in input order. The image border is zero-padded, so each frame
// yields exactly IMG_W*IMG_H outputs. After the last pixel of a frame the
// engine pushes IMG_W+1 internal zero pixels to drain the window. During that
// time busy is high and input is refused.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : pix_data is valid this cycle
//   pix_data   : unsigned pixel, raster order
//   mode       : 0=|Gx|+|Gy|, 1=|Gx|, 2=|Gy|, 3=threshold (sampled at first pixel)
//   thresh     : threshold for mode 3 (sampled at first pixel)
//   busy       : high = input not accepted (frame flush in progress)
//   valid      : edge_out carries a result this cycle
//   edge_out   : edge result
//   frame_done : one-cycle pulse together with the last output of a frame
// -----------------------------------------------------------------------------
module sede_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W+2:0] thresh,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] edge_out,
    output logic              frame_done
);

    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int N_PUSH = N_PIX + IMG_W;   // index of the final zero push
    localparam int CNT_W  = $clog2(N_PUSH + 2);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int SUM_W  = DATA_W + 3;
    localparam int ABS_W  = DATA_W + 2;

    localparam logic [CNT_W-1:0] LAST_PIX_C  = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] LAST_PUSH_C = CNT_W'(N_PUSH);
    localparam logic [CNT_W-1:0] ONE_ROW_C   = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] TWO_ROWS_C  = CNT_W'(2 * IMG_W);
    localparam logic [CNT_W-1:0] FIRST_OUT_C = CNT_W'(IMG_W + 1);
    localparam logic [COL_W-1:0] COL_MAX_C   = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // p0 + 2*p1 + p2 over one window column
    function automatic logic [SUM_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
        wsum = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    // |v| fits in ABS_W bits, so the negation can be done on the low bits only
    function automatic logic [ABS_W-1:0] absv(input logic [SUM_W-1:0] v);
        if (v[SUM_W-1]) begin
            absv = ~v[ABS_W-1:0] + {{(ABS_W-1){1'b0}}, 1'b1};
        end else begin
            absv = v[ABS_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [SUM_W-1:0] v);
        if (|v[SUM_W-1:DATA_W]) begin
            sat = {DATA_W{1'b1}};
        end else begin
            sat = v[DATA_W-1:0];
        end
    endfunction

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   push_cnt_q;     // index of the next push within the frame
    logic [COL_W-1:0]   col_q;          // column of the next push
    logic [1:0]         mode_q;
    logic [DATA_W+2:0]  thresh_q;

    logic [DATA_W-1:0]  lb1_q [IMG_W];  // previous row
    logic [DATA_W-1:0]  lb2_q [IMG_W];  // row before that
    logic [DATA_W-1:0]  win_t_q [3];    // window, index 2 = newest column
    logic [DATA_W-1:0]  win_m_q [3];
    logic [DATA_W-1:0]  win_b_q [3];

    logic               s1_valid_q, s1_first_q, s1_lastc_q, s1_last_q;
    logic               s2_valid_q, s2_last_q;
    logic [ABS_W-1:0]   s2_ax_q, s2_ay_q;
    logic               valid_q, frame_done_q;
    logic [DATA_W-1:0]  edge_q;

    logic               acc_s, flush_push_s, push_s;
    logic [DATA_W-1:0]  pix_in_s, top_in_s, mid_in_s;
    logic [DATA_W-1:0]  lt_s, lm_s, lb_s, rt_s, rm_s, rb_s, tc_s, bc_s;
    logic [SUM_W-1:0]   gx_s, gy_s, sum_s;
    logic [DATA_W-1:0]  res_s;

    // The cycle between the last accept and busy rising is already FLUSH,
    // so input is refused there even though busy still reads low.
    assign acc_s        = in_valid && !busy_q && (state_q != S_FLUSH);
    assign flush_push_s = (state_q == S_FLUSH) && (push_cnt_q <= LAST_PUSH_C);
    assign push_s       = acc_s || flush_push_s;

    // Incoming window column; rows above the image read as zero
    always_comb begin
        pix_in_s = flush_push_s ? {DATA_W{1'b0}} : pix_data;
        if (push_cnt_q < TWO_ROWS_C) begin
            top_in_s = {DATA_W{1'b0}};
        end else begin
            top_in_s = lb2_q[col_q];
        end
        if (push_cnt_q < ONE_ROW_C) begin
            mid_in_s = {DATA_W{1'b0}};
        end else begin
            mid_in_s = lb1_q[col_q];
        end
    end

    // Line buffers and 3x3 window advance on every push
    always_ff @(posedge clk) begin
        if (push_s) begin
            lb1_q[col_q] <= pix_in_s;
            lb2_q[col_q] <= lb1_q[col_q];
            win_t_q[0]   <= win_t_q[1];
            win_t_q[1]   <= win_t_q[2];
            win_t_q[2]   <= top_in_s;
            win_m_q[0]   <= win_m_q[1];
            win_m_q[1]   <= win_m_q[2];
            win_m_q[2]   <= mid_in_s;
            win_b_q[0]   <= win_b_q[1];
            win_b_q[1]   <= win_b_q[2];
            win_b_q[2]   <= pix_in_s;
        end
    end

    // Column padding and Sobel gradients for the current window centre
    always_comb begin
        lt_s = s1_first_q ? {DATA_W{1'b0}} : win_t_q[0];
        lm_s = s1_first_q ? {DATA_W{1'b0}} : win_m_q[0];
        lb_s = s1_first_q ? {DATA_W{1'b0}} : win_b_q[0];
        rt_s = s1_lastc_q ? {DATA_W{1'b0}} : win_t_q[2];
        rm_s = s1_lastc_q ? {DATA_W{1'b0}} : win_m_q[2];
        rb_s = s1_lastc_q ? {DATA_W{1'b0}} : win_b_q[2];
        tc_s = win_t_q[1];
        bc_s = win_b_q[1];
        gx_s = wsum(rt_s, rm_s, rb_s) - wsum(lt_s, lm_s, lb_s);
        gy_s = wsum(lb_s, bc_s, rb_s) - wsum(lt_s, tc_s, rt_s);
    end

    // Output selection by the frame's sampled mode
    always_comb begin
        sum_s = {1'b0, s2_ax_q} + {1'b0, s2_ay_q};
        case (mode_q)
            2'd0:    res_s = sat(sum_s);
            2'd1:    res_s = sat({1'b0, s2_ax_q});
            2'd2:    res_s = sat({1'b0, s2_ay_q});
            2'd3:    res_s = (sum_s >= thresh_q) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default: res_s = {DATA_W{1'b0}};
        endcase
    end

    // Frame control: counters, mode/threshold capture and flush sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            push_cnt_q <= {CNT_W{1'b0}};
            col_q      <= {COL_W{1'b0}};
            mode_q     <= 2'd0;
            thresh_q   <= {(DATA_W+3){1'b0}};
        end else begin
            if (push_s) begin
                push_cnt_q <= push_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                col_q      <= (col_q == COL_MAX_C) ? {COL_W{1'b0}}
                                                   : col_q + {{(COL_W-1){1'b0}}, 1'b1};
            end
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (acc_s) begin
                        mode_q   <= mode;
                        thresh_q <= thresh;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    busy_q <= 1'b0;
                    if (acc_s && (push_cnt_q == LAST_PIX_C)) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // leave on the edge after the frame's last output
                    if (frame_done_q) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        push_cnt_q <= {CNT_W{1'b0}};
                        col_q      <= {COL_W{1'b0}};
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result pipeline: window flags -> absolute gradients -> output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_lastc_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_ax_q      <= {ABS_W{1'b0}};
            s2_ay_q      <= {ABS_W{1'b0}};
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            edge_q       <= {DATA_W{1'b0}};
        end else begin
            // the window centre lags the pushed pixel by IMG_W+1 positions
            s1_valid_q   <= push_s && (push_cnt_q >= FIRST_OUT_C);
            s1_first_q   <= (col_q == COL_W'(1));
            s1_lastc_q   <= (col_q == {COL_W{1'b0}});
            s1_last_q    <= (push_cnt_q == LAST_PUSH_C);
            s2_valid_q   <= s1_valid_q;
            s2_last_q    <= s1_last_q;
            s2_ax_q      <= absv(gx_s);
            s2_ay_q      <= absv(gy_s);
            valid_q      <= s2_valid_q;
            frame_done_q <= s2_valid_q && s2_last_q;
            edge_q       <= s2_valid_q ? res_s : {DATA_W{1'b0}};
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign edge_out   = edge_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sede_param.sv
module tb_sede_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: default 8-bit 32x32
    logic        a_rst, a_in_valid, a_busy, a_valid, a_fd;
    logic [7:0]  a_pix, a_edge;
    logic [1:0]  a_mode;
    logic [10:0] a_thresh;
    // instance B: 10-bit 8x4
    logic        b_rst, b_in_valid, b_busy, b_valid, b_fd;
    logic [9:0]  b_pix, b_edge;
    logic [1:0]  b_mode;
    logic [12:0] b_thresh;

    sede_param dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .pix_data(a_pix),
        .mode(a_mode), .thresh(a_thresh), .busy(a_busy), .valid(a_valid),
        .edge_out(a_edge), .frame_done(a_fd)
    );

    sede_param #(.DATA_W(10), .IMG_W(8), .IMG_H(4)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .pix_data(b_pix),
        .mode(b_mode), .thresh(b_thresh), .busy(b_busy), .valid(b_valid),
        .edge_out(b_edge), .frame_done(b_fd)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int a_out[$];
    int a_t[$];
    int a_fd_cnt = 0;
    int a_fd_pos = -1;
    int b_out[$];
    int b_fd_cnt = 0;
    int b_fd_pos = -1;

    // output collectors, sampled away from the active edge
    always @(negedge clk) begin
        if (a_fd === 1'b1) begin
            a_fd_cnt = a_fd_cnt + 1;
            a_fd_pos = a_out.size();
        end
        if (a_valid === 1'b1) begin
            a_out.push_back(int'(a_edge));
            a_t.push_back(cyc);
        end
        if (b_fd === 1'b1) begin
            b_fd_cnt = b_fd_cnt + 1;
            b_fd_pos = b_out.size();
        end
        if (b_valid === 1'b1) begin
            b_out.push_back(int'(b_edge));
        end
    end

    int img_a[1024];
    int img_b[32];
    int ref_out[1024];

    function automatic int px(input int which, input int r, input int c);
        int w;
        int h;
        w = (which == 0) ? 32 : 8;
        h = (which == 0) ? 32 : 4;
        if (r < 0 || r >= h || c < 0 || c >= w) return 0;
        return (which == 0) ? img_a[r*w+c] : img_b[r*w+c];
    endfunction

    function automatic int model(input int which, input int k, input int md, input int th);
        int w, r, c, gx, gy, ax, ay, mx, s;
        w  = (which == 0) ? 32 : 8;
        mx = (which == 0) ? 255 : 1023;
        r  = k / w;
        c  = k % w;
        gx = (px(which,r-1,c+1) + 2*px(which,r,c+1) + px(which,r+1,c+1))
           - (px(which,r-1,c-1) + 2*px(which,r,c-1) + px(which,r+1,c-1));
        gy = (px(which,r+1,c-1) + 2*px(which,r+1,c) + px(which,r+1,c+1))
           - (px(which,r-1,c-1) + 2*px(which,r-1,c) + px(which,r-1,c+1));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (md)
            0: s = ax + ay;
            1: s = ax;
            2: s = ay;
            default: return ((ax + ay) >= th) ? mx : 0;
        endcase
        return (s > mx) ? mx : s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_at(input int which, input int k);
        if (which == 0) return (k < a_out.size()) ? a_out[k] : -1;
        return (k < b_out.size()) ? b_out[k] : -1;
    endfunction

    task automatic drive(input int which, input bit v, input int pix, input int md, input int th);
        if (which == 0) begin
            a_in_valid = v; a_pix = 8'(pix); a_mode = 2'(md); a_thresh = 11'(th);
        end else begin
            b_in_valid = v; b_pix = 10'(pix); b_mode = 2'(md); b_thresh = 13'(th);
        end
    endtask

    // Streams one frame (or its first stop_k pixels); mode switches to md2 at pixel sw_k.
    task automatic run_frame(input int which, input int md, input int th, input int md2,
                             input int sw_k, input bit gaps, input int stop_k,
                             output int busy_cycles);
        int n, guard, pix;
        bit seen, bz;
        n = (which == 0) ? 1024 : 32;
        guard = 0;
        bz = (which == 0) ? a_busy : b_busy;
        while (bz && guard < 100) begin
            @(negedge clk);
            guard++;
            bz = (which == 0) ? a_busy : b_busy;
        end
        check("idle_before_frame", int'(bz), 0);
        if (which == 0) begin
            a_out.delete(); a_t.delete(); a_fd_cnt = 0; a_fd_pos = -1;
        end else begin
            b_out.delete(); b_fd_cnt = 0; b_fd_pos = -1;
        end
        for (int k = 0; k < stop_k; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    @(negedge clk);
                    drive(which, 1'b0, 0, md, th);
                end
            end
            @(negedge clk);
            pix = (which == 0) ? img_a[k] : img_b[k];
            drive(which, 1'b1, pix, (k < sw_k) ? md : md2, th);
        end
        @(negedge clk);
        drive(which, 1'b0, 0, md2, th);
        busy_cycles = 0;
        if (stop_k < n) return;
        seen = 1'b0;
        guard = 0;
        while (guard < 200) begin
            bz = (which == 0) ? a_busy : b_busy;
            if (bz) begin
                seen = 1'b1;
                busy_cycles++;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic check_frame(input int which, input string tag, input int md, input int th);
        int n, sz, mism, first_bad;
        n  = (which == 0) ? 1024 : 32;
        sz = (which == 0) ? a_out.size() : b_out.size();
        check({tag, "_count"}, sz, n);
        check({tag, "_fd_pulses"}, (which == 0) ? a_fd_cnt : b_fd_cnt, 1);
        check({tag, "_fd_pos"}, (which == 0) ? a_fd_pos : b_fd_pos, n - 1);
        mism = 0;
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (out_at(which, k) != model(which, k, md, th)) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (mism != 0) $display("%s: first differing output index %0d", tag, first_bad);
        check({tag, "_model_diffs"}, mism, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int cnt;
        a_rst = 1'b1;
        b_rst = 1'b1;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_a_valid", int'(a_valid), 0);
        check("reset_a_busy", int'(a_busy), 0);
        check("reset_a_edge", int'(a_edge), 0);
        check("reset_a_fd", int'(a_fd), 0);
        check("reset_b_valid", int'(b_valid), 0);
        check("reset_b_busy", int'(b_busy), 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);

        // uniform 100, mode 0
        for (int k = 0; k < 1024; k++) img_a[k] = 100;
        run_frame(0, 0, 0, 0, 1024, 1'b0, 1024, bc);
        check_frame(0, "uniform", 0, 0);
        check("uniform_corner_tl", out_at(0, 0), 255);
        check("uniform_corner_tr", out_at(0, 31), 255);
        check("uniform_corner_bl", out_at(0, 992), 255);
        check("uniform_corner_br", out_at(0, 1023), 255);
        check("uniform_top_edge", out_at(0, 5), 255);
        check("uniform_left_edge", out_at(0, 320), 255);
        check("uniform_interior", out_at(0, 10*32+10), 0);
        check("uniform_busy_cycles", bc, 35);

        // vertical step, |Gx|
        for (int k = 0; k < 1024; k++) img_a[k] = ((k % 32) < 16) ? 0 : 40;
        run_frame(0, 1, 0, 1, 1024, 1'b0, 1024, bc);
        check_frame(0, "step_gx", 1, 0);
        check("step_gx_c14", out_at(0, 10*32+14), 0);
        check("step_gx_c15", out_at(0, 10*32+15), 160);
        check("step_gx_c16", out_at(0, 10*32+16), 160);
        check("step_gx_c17", out_at(0, 10*32+17), 0);

        // vertical step, threshold 100
        run_frame(0, 3, 100, 3, 1024, 1'b0, 1024, bc);
        check_frame(0, "step_t100", 3, 100);
        check("step_t100_c14", out_at(0, 10*32+14), 0);
        check("step_t100_c15", out_at(0, 10*32+15), 255);
        check("step_t100_c16", out_at(0, 10*32+16), 255);
        check("step_t100_c17", out_at(0, 10*32+17), 0);

        // vertical step, threshold 161: interior all zero
        run_frame(0, 3, 161, 3, 1024, 1'b0, 1024, bc);
        check_frame(0, "step_t161", 3, 161);
        cnt = 0;
        for (int r = 1; r < 31; r++)
            for (int c = 1; c < 31; c++)
                if (out_at(0, r*32+c) != 0) cnt++;
        check("step_t161_interior_nonzero", cnt, 0);

        // random image, continuous then gapped
        for (int k = 0; k < 1024; k++) img_a[k] = int'($urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 1024, 1'b0, 1024, bc);
        check_frame(0, "rand_cont", 0, 0);
        for (int k = 0; k < 1024; k++) ref_out[k] = out_at(0, k);
        run_frame(0, 0, 0, 0, 1024, 1'b1, 1024, bc);
        check_frame(0, "rand_gap", 0, 0);
        cnt = 0;
        for (int k = 0; k < 1024; k++) if (out_at(0, k) != ref_out[k]) cnt++;
        check("rand_gap_vs_cont", cnt, 0);
        check("rand_gap_busy_cycles", bc, 35);
        check("rand_gap_tail_b2b", (a_t.size() == 1024) ? (a_t[1023] - a_t[991]) : -1, 32);

        // reset after 500 accepted pixels, then a fresh frame
        for (int k = 0; k < 1024; k++) img_a[k] = int'($urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 1024, 1'b0, 500, bc);
        a_rst = 1'b1;
        #1;
        check("abort_valid_now", int'(a_valid), 0);
        check("abort_edge_now", int'(a_edge), 0);
        a_out.delete(); a_t.delete(); a_fd_cnt = 0;
        @(negedge clk);
        check("abort_valid_next", int'(a_valid), 0);
        a_rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_residue", a_out.size() + a_fd_cnt, 0);
        for (int k = 0; k < 1024; k++) img_a[k] = int'($urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 1024, 1'b0, 1024, bc);
        check_frame(0, "fresh", 0, 0);

        // small instance: mode change mid-frame is ignored
        for (int k = 0; k < 32; k++) img_b[k] = int'($urandom_range(0, 1023));
        run_frame(1, 0, 0, 2, 10, 1'b0, 32, bc);
        check_frame(1, "small_mode0", 0, 0);
        check("small_busy_cycles", bc, 11);
        for (int k = 0; k < 32; k++) img_b[k] = 1023;
        run_frame(1, 2, 0, 2, 32, 1'b0, 32, bc);
        check_frame(1, "small_mode2", 2, 0);
        check("small_corner_tl", out_at(1, 0), 1023);
        check("small_corner_br", out_at(1, 31), 1023);
        check("small_interior", out_at(1, 9), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
